// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receiver-side and consumer-side signal bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  logic              rx_done_i;
  logic [DATA_W-1:0] rx_data_i;
  logic              rx_en_o;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic [AW:0]       count;
  logic              almost_full;
  logic              overflow;
  logic              clr_ovf;

  // FIFO side: owns the buffered stream and status
  modport master (
    input  rx_done_i, rx_data_i, m_ready, clr_ovf,
    output rx_en_o, m_valid, m_data, count, almost_full, overflow
  );

  // Environment side: receiver plus consumer
  modport slave (
    output rx_done_i, rx_data_i, m_ready, clr_ovf,
    input  rx_en_o, m_valid, m_data, count, almost_full, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - edge-detected UART receive byte FIFO with FWFT output
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AFULL  = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_fifo_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              r_rx_done_d;
  logic              r_overflow;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              w_wr;
  logic              w_drop;
  logic [AW:0]       w_count;

  // A long completion strobe yields exactly one push on its rising edge
  assign w_push  = bus.rx_done_i & ~r_rx_done_d;
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = ~w_empty & bus.m_ready;
  // A pop in the same cycle frees the slot, so a push while full is still taken
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_count = r_wr_ptr - r_rd_ptr;

  assign bus.m_valid     = ~w_empty;
  assign bus.m_data      = r_mem[r_rd_ptr[AW-1:0]];
  assign bus.rx_en_o     = ~w_full;
  assign bus.count       = w_count;
  assign bus.almost_full = (w_count >= AFULL_C);
  assign bus.overflow    = r_overflow;

  // Strobe history and pointer advance; reset discards stored bytes at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_done_d <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_rx_done_d <= bus.rx_done_i;
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_overflow <= 1'b0;
    else if (w_drop)      r_overflow <= 1'b1;
    else if (bus.clr_ovf) r_overflow <= 1'b0;
  end

  // Byte storage, intentionally without reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= bus.rx_data_i;
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  uart_rx_fifo_if #(.DATA_W(8), .DEPTH(16)) bus ();

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .AFULL(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       done;
    logic [7:0] data;
    logic       ready;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [4:0] exp_count;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic rdy, input logic clr);
    bus.rx_data_i = d;
    bus.rx_done_i = 1'b1;
    bus.m_ready   = rdy;
    bus.clr_ovf   = clr;
    tick();
    bus.rx_done_i = 1'b0;
    bus.m_ready   = 1'b0;
    bus.clr_ovf   = 1'b0;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n         = 1'b0;
    bus.rx_done_i = 1'b0;
    bus.rx_data_i = 8'h00;
    bus.m_ready   = 1'b0;
    bus.clr_ovf   = 1'b0;

    //                done data  rdy clr  valid data  cnt ovf
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0};
    vecs[3]  = '{1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0};
    vecs[4]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd2, 1'b0};
    vecs[5]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0};
    vecs[6]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 5'd1, 1'b0};
    vecs[7]  = '{1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    vecs[8]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 5'd1, 1'b0};
    vecs[9]  = '{1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 5'd1, 1'b0};
    vecs[10] = '{1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};

    // Reset state
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_rx_en", 32'(bus.rx_en_o), 32'd1);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_afull", 32'(bus.almost_full), 32'd0);

    // Table: long strobe, FWFT latency, simultaneous push/pop
    for (int i = 0; i < 11; i++) begin
      bus.rx_done_i = vecs[i].done;
      bus.rx_data_i = vecs[i].data;
      bus.m_ready   = vecs[i].ready;
      bus.clr_ovf   = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.m_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
      chk($sformatf("vec%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_data", i), 32'(bus.m_data), 32'(vecs[i].exp_data));
    end
    bus.rx_done_i = 1'b0;
    bus.m_ready   = 1'b0;
    tick();

    // Ordering and pointer wrap with a consumer that is always ready
    bus.m_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.rx_data_i = 8'(i % 16);
      bus.rx_done_i = 1'b1;
      tick();
      chk($sformatf("wrap%0d_valid", i), 32'(bus.m_valid), 32'd1);
      chk($sformatf("wrap%0d_data", i), 32'(bus.m_data), 32'(i % 16));
      chk($sformatf("wrap%0d_cnt1", i), 32'(bus.count), 32'd1);
      bus.rx_done_i = 1'b0;
      tick();
      chk($sformatf("wrap%0d_cnt0", i), 32'(bus.count), 32'd0);
    end
    bus.m_ready = 1'b0;

    // Fill to full with thresholds
    for (int i = 0; i < 16; i++) begin
      push(8'h80 + 8'(i), 1'b0, 1'b0);
      if (i == 10) chk("fill_afull_11", 32'(bus.almost_full), 32'd0);
      if (i == 11) chk("fill_afull_12", 32'(bus.almost_full), 32'd1);
      if (i == 14) chk("fill_rx_en_15", 32'(bus.rx_en_o), 32'd1);
    end
    chk("full_count", 32'(bus.count), 32'd16);
    chk("full_rx_en", 32'(bus.rx_en_o), 32'd0);
    chk("full_afull", 32'(bus.almost_full), 32'd1);
    chk("full_ovf0", 32'(bus.overflow), 32'd0);

    // Drop while full
    push(8'hEE, 1'b0, 1'b0);
    chk("drop_ovf", 32'(bus.overflow), 32'd1);
    chk("drop_count", 32'(bus.count), 32'd16);
    chk("drop_head", 32'(bus.m_data), 32'h80);

    // Drop coinciding with a clear: set wins
    push(8'hDD, 1'b0, 1'b1);
    chk("setwin_ovf", 32'(bus.overflow), 32'd1);
    chk("setwin_count", 32'(bus.count), 32'd16);

    // Plain clear
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    chk("clr_count", 32'(bus.count), 32'd16);

    // Push with pop while full
    push(8'h77, 1'b1, 1'b0);
    chk("fullpp_count", 32'(bus.count), 32'd16);
    chk("fullpp_ovf", 32'(bus.overflow), 32'd0);
    chk("fullpp_head", 32'(bus.m_data), 32'h81);

    // Drain: 81..8F then 77, no dropped bytes
    bus.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(bus.m_valid), 32'd1);
      chk($sformatf("drain%0d_data", i), 32'(bus.m_data),
          (i == 15) ? 32'h77 : 32'(8'h81 + 8'(i)));
      tick();
    end
    bus.m_ready = 1'b0;
    chk("drain_count", 32'(bus.count), 32'd0);
    chk("drain_valid", 32'(bus.m_valid), 32'd0);
    chk("drain_rx_en", 32'(bus.rx_en_o), 32'd1);

    // Asynchronous reset with bytes stored
    push(8'h01, 1'b0, 1'b0);
    push(8'h02, 1'b0, 1'b0);
    push(8'h03, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(bus.count), 32'd0);
    chk("async_rst_valid", 32'(bus.m_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_count", 32'(bus.count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
